// File: rtl/uart_ascii_rx.sv
// UART 8N1 receiver: recovers bytes from an asynchronous serial line and presents each
// good byte on ascii with a one-cycle ascii_val pulse; stop-bit errors pulse frame_err.
module uart_ascii_rx #(
  parameter int unsigned p_clks_per_bit = 868,
  parameter int unsigned p_sync_stages  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] ascii,
  output logic       ascii_val,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(p_clks_per_bit);
  // Counter counts down to zero, so a period of N clocks is loaded as N-1.
  localparam logic [CntW-1:0] BitLoad  = CntW'(p_clks_per_bit - 1);
  localparam logic [CntW-1:0] HalfLoad = CntW'(p_clks_per_bit / 2 - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } state_e;

  state_e                   state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [2:0]               bit_idx_q, bit_idx_d;
  logic [7:0]               shift_q, shift_d;
  logic [7:0]               ascii_q, ascii_d;
  logic                     val_q, val_d;
  logic                     err_q, err_d;
  logic [p_sync_stages-1:0] sync_q, sync_d;

  logic rx_s;
  logic cnt_zero;

  assign rx_s     = sync_q[p_sync_stages-1];
  assign cnt_zero = (cnt_q == '0);

  // Metastability synchronizer: shift raw rx toward the last stage.
  always_comb begin
    sync_d = {sync_q[p_sync_stages-2:0], rx};
  end

  // Frame sequencing: start validation, mid-bit sampling and output pulse generation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_zero ? cnt_q : cnt_q - 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    ascii_d   = ascii_q;
    val_d     = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          cnt_d   = HalfLoad;
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_zero) begin
          if (!rx_s) begin
            cnt_d     = BitLoad;
            bit_idx_d = 3'd0;
            state_d   = StData;
          end else begin
            // Line went back high before mid-start: treat as a glitch.
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (cnt_zero) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = BitLoad;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (cnt_zero) begin
          if (rx_s) begin
            ascii_d = shift_q;
            val_d   = 1'b1;
            // Leaving at the stop midpoint lets a start bit right after the stop be caught.
            state_d = StIdle;
          end else begin
            err_d   = 1'b1;
            state_d = StWaitIdle;
          end
        end
      end
      StWaitIdle: begin
        // Ignore the low line (break) until it returns to idle.
        if (rx_s) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with asynchronous active-low reset; synchronizer presets to idle-high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      ascii_q   <= 8'h00;
      val_q     <= 1'b0;
      err_q     <= 1'b0;
      sync_q    <= '1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      ascii_q   <= ascii_d;
      val_q     <= val_d;
      err_q     <= err_d;
      sync_q    <= sync_d;
    end
  end

  assign ascii     = ascii_q;
  assign ascii_val = val_q;
  assign frame_err = err_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: doc/uart_ascii_rx.md
Name: uart_ascii_rx

Overview:
- UART 8N1 receiver that feeds the character display's ASCII interface (`ascii` / `ascii_val`).
- Recovers bytes from an asynchronous serial line and emits each good byte as a one-cycle valid pulse.
- Sits between the board's serial RX pin and the character display, in the display's system-clock domain.
- Flags stop-bit framing errors and discards the affected byte.

Parameters:
- p_clks_per_bit, 868, system clocks per serial bit (100 MHz / 115200 baud); legal range >= 4.
- p_sync_stages, 2, flip-flop stages in the rx metastability synchronizer; legal range >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset; asserting low immediately resets all state.
- rx  input  1  raw serial line; idles high, asynchronous to clk.
- ascii  output  8  last correctly received byte.
- ascii_val  output  1  one-cycle pulse; ascii holds a new byte this cycle.
- frame_err  output  1  one-cycle pulse; the stop bit was sampled low.
- busy  output  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- Reset (rst low, asynchronous):
  - State = IDLE; bit counter and baud counter cleared.
  - Synchronizer flops preset to 1 (line idle), so no false start bit on release.
  - Outputs: ascii=8'h00, ascii_val=0, frame_err=0, busy=0.
- Synchronizer: rx passes through p_sync_stages flops; rx_s is the last stage. All decisions use rx_s only.
- Baud counter width is $clog2(p_clks_per_bit).
- Half bit means floor(p_clks_per_bit/2) clocks.
- States:
  - IDLE: on rx_s==0, load baud counter for half a bit and go to START.
  - START: at half-bit expiry, resample rx_s.
    - 0: genuine start bit; load full bit period, clear bit index, go to DATA.
    - 1: glitch; return to IDLE with no output.
  - DATA: every p_clks_per_bit clocks, sample rx_s into the shift register, LSB first.
    - After bit index 7 is sampled, load full bit period and go to STOP.
  - STOP: at expiry, sample rx_s.
    - 1: next cycle ascii <= shifted byte, ascii_val=1 for exactly one cycle; go to IDLE.
    - 0: next cycle frame_err=1 for one cycle, ascii unchanged, no ascii_val; go to WAIT_IDLE.
  - WAIT_IDLE: remain until rx_s==1 (break/line-low condition), then go to IDLE. No new start is detected while here.
- Sampling point: every bit is sampled at its midpoint.
- Latency, measured from the rx falling edge of the start bit:
  - ascii_val at p_sync_stages + half bit + 9*p_clks_per_bit + 1 clocks (±1 clk for edge alignment).
- Output invariants:
  - ascii_val and frame_err are never high in the same cycle.
  - Neither is asserted twice for one frame.
- ascii holds its value between pulses; the downstream display samples it only on ascii_val. There is no backpressure, so the consumer must accept every pulse.
- Back-to-back frames: returning to IDLE at the stop-bit midpoint means a start bit immediately following the stop bit is detected correctly.
- busy is 1 in START, DATA, STOP and WAIT_IDLE.
- Reset mid-frame: the partial byte is discarded, no pulse is generated, and reception resumes on the next falling edge after rst deasserts.

Test Plan:
- Reset check: hold rst=0 with rx toggling -> ascii=00, ascii_val=0, frame_err=0, busy=0 throughout; release -> no spurious pulse while rx stays high.
- Single byte: p_clks_per_bit=8; send 8N1 frame 0x41 ('A') -> exactly one ascii_val pulse, ascii=8'h41, arriving 2+4+72+1=79 clks (±1) after the start edge; busy falls the same cycle.
- Glitch rejection: drive rx low for 2 clks, then high -> busy rises, then returns to IDLE; no ascii_val and no frame_err; the next valid frame 0x7A is received correctly.
- Framing error: send 0x55 with stop bit 0, hold rx low 30 clks, then high -> one frame_err pulse, ascii keeps its prior value, no ascii_val, busy stays 1 until rx returns high.
- Back-to-back: send 0x48, 0x69 ("Hi") with no idle gap -> two ascii_val pulses 80 clks apart (±1), ascii=48 then 69.
- Reset mid-frame: pull rst low during data bit 4 of 0xFF, release, then send 0x30 -> only one pulse total, ascii=8'h30.
